loop_iter_ctrl_group: RTL
=========================

Name: loop_iter_ctrl_group

Overview:
- Nested-loop iteration controller that drives `mem_walker_stride_group`; this block is the producing end of that block's `iter_done` / `start` / `stall` / group interface.
- The instruction decoder programs per-group loop trip counts.
- On `start`, the block steps through the configured loop nest of the selected group, one innermost iteration per non-stalled cycle.
- Each cycle it emits the `iter_done` wrap vector and the active loop group id, which the address walkers of a systolic-array operand path consume.

Parameters:
- LOOP_ID_W, 5, width of loop index; NUM_MAX_LOOPS = 1<<LOOP_ID_W.
- GROUP_ID_W, 2, width of group id; NUM_MAX_GROUPS = 1<<GROUP_ID_W.
- ITER_W, 16, width of a trip-count field (value programmed = trips-1).
- GROUP_ENABLED, 1, 0 forces all group ids to 0 and instantiates one group table.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_loop_iter_v  in  1  trip-count write strobe.
- cfg_loop_iter  in  ITER_W  trips-1 for next loop slot.
- cfg_loop_group_id  in  GROUP_ID_W  group table being written.
- block_done  in  1  clears all tables and write pointers.
- start  in  1  single-cycle pulse, begin nest.
- start_group_id  in  GROUP_ID_W  group to execute, sampled with start.
- stall  in  1  downstream backpressure, freezes stepping.
- iter_done  out  NUM_MAX_LOOPS+1  wrap vector (see Behaviour).
- loop_group_id  out  GROUP_ID_W  group currently executing.
- busy  out  1  high while in RUN.
- nest_done  out  1  registered one-cycle pulse after final iteration.

Behaviour:
- Reset (reset==0, asynchronous):
  - State = IDLE; all tables, write pointers, loop counters, loop_group_id = 0.
  - busy = 0, nest_done = 0, iter_done = 0.
- Configuration:
  - Each group has a write pointer `wptr[g]` (LOOP_ID_W bits).
  - When cfg_loop_iter_v is high, table[g][wptr[g]] <= cfg_loop_iter and wptr[g] increments.
  - The pointer wraps modulo NUM_MAX_LOOPS and overwrites slot 0.
  - Slot 0 is the outermost loop; slot NUM_MAX_LOOPS-1 is the innermost. Unwritten slots hold 0, i.e. one trip.
- block_done:
  - Clears every table entry and every wptr.
  - Priority over a same-cycle cfg write, which is dropped.
  - Ignored while busy.
- Writes to the executing group's table while busy are dropped; writes to other groups are accepted.
- IDLE state:
  - start -> RUN. Same-edge actions: loop_group_id <= start_group_id (0 when GROUP_ENABLED==0); all cnt[i] <= 0.
- RUN state:
  - step = ~stall. On a step, the innermost counter increments.
  - cnt[i] increments only when all inner loops j>i are at their last trip.
  - A counter reaching table value resets to 0.
- iter_done is combinational from counters and step, zero when not stepping and in IDLE:
  - iter_done[NUM_MAX_LOOPS] = step.
  - iter_done[k] (k=0..NUM_MAX_LOOPS-1) = step AND cnt[j]==table[j] for all j>=k.
  - iter_done[0] marks the final iteration of the nest.
- Completion:
  - A step with iter_done[0]=1 -> IDLE next edge, busy=0.
  - nest_done pulses for one cycle on the cycle after that edge.
- Total steps per nest = product over all slots of (table+1). Latency from start to first iter_done = 1 cycle (the first RUN cycle).
- start while RUN is ignored.
- start on the same edge as the final step is ignored; a new start is needed once in IDLE.
- stall held high freezes counters and forces iter_done = 0; stepping resumes the cycle stall drops.
- Reset asserted mid-RUN aborts immediately, with no nest_done.
- loop_group_id holds its value after completion until the next start.

Test Plan:
- (Tests use LOOP_ID_W=2, i.e. 4 loops.)
- Program group 0 slots 0,1 = 1,2 (2×3 trips), start group 0, stall=0 -> exactly 6 step cycles:
  - iter_done[4] high all 6 cycles; iter_done[3:2] high all 6 cycles.
  - iter_done[1] high on steps 3 and 6; iter_done[0] only on step 6.
  - nest_done pulses 1 cycle later.
- Same config, stall high for steps 2-4 (3 cycles) -> iter_done = 0 during stall, counters frozen; total 6 steps over 9 cycles; wrap pattern identical to the first test.
- Program group 1 slot 0 = 3 and group 0 as in the first test, start group 1 -> loop_group_id=1, 4 steps, iter_done[0] on 4th; then start group 0 -> loop_group_id=0, 6 steps.
- cfg_loop_iter_v and block_done in same cycle, then start -> write dropped, all slots 0, single step with iter_done = 5'b11111.
- Assert reset low mid-RUN at step 3 -> busy=0 and iter_done=0 immediately, no nest_done, tables cleared; start after release gives a 1-step nest.
- Second start during RUN, and a cfg write to the active group during RUN -> both ignored; nest completes with original 6-step count.

Source files
------------

// File: rtl/loop_iter_ctrl_group.sv
// Nested-loop iteration controller. Holds per-group trip-count tables written
// by the decoder and, once started, steps through the selected loop nest one
// innermost iteration per non-stalled cycle, emitting the iter_done wrap vector.
module loop_iter_ctrl_group #(
    parameter int LOOP_ID_W     = 5,
    parameter int GROUP_ID_W    = 2,
    parameter int ITER_W        = 16,
    parameter int GROUP_ENABLED = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cfg_loop_iter_v,
    input  logic [ITER_W-1:0]         i_cfg_loop_iter,
    input  logic [GROUP_ID_W-1:0]     i_cfg_loop_group_id,
    input  logic                      i_block_done,
    input  logic                      i_start,
    input  logic [GROUP_ID_W-1:0]     i_start_group_id,
    input  logic                      i_stall,
    output logic [(1<<LOOP_ID_W):0]   o_iter_done,
    output logic [GROUP_ID_W-1:0]     o_loop_group_id,
    output logic                      o_busy,
    output logic                      o_nest_done
);
    localparam int NUM_MAX_LOOPS = 1 << LOOP_ID_W;
    // With groups disabled only one table exists and every id folds to 0.
    localparam int NUM_TBL       = (GROUP_ENABLED != 0) ? (1 << GROUP_ID_W) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  r_state;
    logic [GROUP_ID_W-1:0]   r_grp;
    logic                    r_nest_done;
    logic [ITER_W-1:0]       r_tbl  [NUM_TBL][NUM_MAX_LOOPS];
    logic [LOOP_ID_W-1:0]    r_wptr [NUM_TBL];
    logic [ITER_W-1:0]       r_cnt  [NUM_MAX_LOOPS];

    logic                    w_busy;
    logic                    w_step;
    logic [GROUP_ID_W-1:0]   w_cfg_g;
    logic [GROUP_ID_W-1:0]   w_start_g;
    logic [NUM_MAX_LOOPS-1:0] w_last;
    logic [NUM_MAX_LOOPS:0]  w_iter_done;

    assign w_busy    = (r_state == RUN);
    assign w_step    = w_busy & ~i_stall;
    assign w_cfg_g   = (GROUP_ENABLED != 0) ? i_cfg_loop_group_id : '0;
    assign w_start_g = (GROUP_ENABLED != 0) ? i_start_group_id : '0;

    // Wrap vector: bit k is set when every loop at or inside k is on its last trip.
    always_comb begin
        w_last      = '0;
        w_iter_done = '0;
        for (int i = 0; i < NUM_MAX_LOOPS; i++)
            w_last[i] = (r_cnt[i] == r_tbl[r_grp][i]);
        w_iter_done[NUM_MAX_LOOPS] = w_step;
        for (int k = NUM_MAX_LOOPS - 1; k >= 0; k--)
            w_iter_done[k] = w_iter_done[k+1] & w_last[k];
    end

    // Trip-count tables: block_done clears (idle only); the running group's table is frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int g = 0; g < NUM_TBL; g++) begin
                r_wptr[g] <= '0;
                for (int i = 0; i < NUM_MAX_LOOPS; i++)
                    r_tbl[g][i] <= '0;
            end
        end else if (i_block_done && !w_busy) begin
            for (int g = 0; g < NUM_TBL; g++) begin
                r_wptr[g] <= '0;
                for (int i = 0; i < NUM_MAX_LOOPS; i++)
                    r_tbl[g][i] <= '0;
            end
        end else if (i_cfg_loop_iter_v && !(w_busy && (w_cfg_g == r_grp))) begin
            r_tbl[w_cfg_g][r_wptr[w_cfg_g]] <= i_cfg_loop_iter;
            r_wptr[w_cfg_g]                 <= r_wptr[w_cfg_g] + LOOP_ID_W'(1);
        end
    end

    // Sequencer: IDLE/RUN state, active group, loop counters and completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_grp       <= '0;
            r_nest_done <= 1'b0;
            for (int i = 0; i < NUM_MAX_LOOPS; i++)
                r_cnt[i] <= '0;
        end else begin
            r_nest_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_grp   <= w_start_g;
                        for (int i = 0; i < NUM_MAX_LOOPS; i++)
                            r_cnt[i] <= '0;
                    end
                end
                RUN: begin
                    // A counter advances only when all loops inside it wrap this step.
                    for (int i = 0; i < NUM_MAX_LOOPS; i++)
                        if (w_iter_done[i+1])
                            r_cnt[i] <= w_last[i] ? '0 : r_cnt[i] + ITER_W'(1);
                    if (w_iter_done[0]) begin
                        r_state     <= IDLE;
                        r_nest_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_iter_done     = w_iter_done;
    assign o_loop_group_id = r_grp;
    assign o_busy          = w_busy;
    assign o_nest_done     = r_nest_done;

endmodule
